// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory access controller with stall, timeout and error strobes
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        RDataValid,
    output logic        Error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        error_q;

    logic op;
    logic illegal;

    assign op      = MemRead | MemWrite;
    assign illegal = (Addr[1:0] != 2'b00) | (MemRead & MemWrite);

    // The pipeline is frozen while a request waits to be accepted or is in flight;
    // DONE releases it so EX/MEM loads the next instruction at the end of that cycle.
    assign Stall = ((state_q == IDLE) & op) | (state_q == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op) begin
                        if (illegal) begin
                            error_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_addr_q  <= Addr;
                            mem_wdata_q <= WData;
                            mem_we_q    <= MemWrite;
                            mem_req_q   <= 1'b1;
                            cnt_q       <= 8'd0;
                            state_q     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A completion on the last allowed cycle wins over the timeout.
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            rdata_q  <= mem_rdata;
                            rvalid_q <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (cnt_q == LAST_CNT) begin
                        error_q   <= 1'b1;
                        rdata_q   <= 32'd0;
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign RData      = rdata_q;
    assign RDataValid = rvalid_q;
    assign Error      = error_q;

endmodule
